// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - write-back staging FIFO with one-hot drain and read forwarding
module regfile_wb_queue #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       drain_en,
    output logic [NUM_REGS-1:0]        WriteReg,
    output logic [DATA_W-1:0]          WriteData,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic [NUM_REGS-1:0]        ReadEnable1,
    output logic [NUM_REGS-1:0]        ReadEnable2,
    input  logic [DATA_W-1:0]          rf_rdata1,
    input  logic [DATA_W-1:0]          rf_rdata2,
    output logic [DATA_W-1:0]          rd_data1,
    output logic [DATA_W-1:0]          rd_data2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wb_ready = !full || drain_en;
    // R0 writes complete the handshake but are never stored.
    assign push     = wb_valid && wb_ready && (wb_addr != '0);
    assign pop      = !empty && drain_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                addr_q[tail] <= wb_addr;
                data_q[tail] <= wb_data;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign WriteReg    = pop ? (NUM_REGS'(1) << addr_q[head]) : '0;
    assign WriteData   = data_q[head];
    assign ReadEnable1 = NUM_REGS'(1) << rd_addr1;
    assign ReadEnable2 = NUM_REGS'(1) << rd_addr2;

    // Walk oldest to youngest so the last match (tail-most) wins.
    function automatic logic [DATA_W-1:0] forward(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] rf_data);
        logic [DATA_W-1:0] result;
        logic [PTR_W-1:0]  idx;
        result = rf_data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_q[idx] == addr)) begin
                result = data_q[idx];
            end
        end
        if (addr == '0) begin
            result = '0;
        end
        return result;
    endfunction

    always_comb begin
        rd_data1 = forward(rd_addr1, rf_rdata1);
        rd_data2 = forward(rd_addr2, rf_rdata2);
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - directed self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        drain_en;
    logic [15:0] WriteReg;
    logic [15:0] WriteData;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [15:0] ReadEnable1, ReadEnable2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [15:0] rd_data1, rd_data2;
    logic [2:0]  count;
    logic        full, empty;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_queue dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .drain_en(drain_en), .WriteReg(WriteReg), .WriteData(WriteData),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; drain_en = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_writereg", WriteReg, 16'h0000);
        check_eq("rst_count", count, 3'd0);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_ready", wb_ready, 1'b1);
        rd_addr1 = 4'd5; rf_rdata1 = 16'h1234;
        #1;
        check_eq("idle_rd1", rd_data1, 16'h1234);
        check_eq("idle_re1", ReadEnable1, 16'h0020);

        // single write with drain enabled
        drain_en = 1'b1; wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF;
        #1;
        check_eq("no_passthru", WriteReg, 16'h0000);
        tick();
        wb_valid = 1'b0;
        check_eq("single_wr", WriteReg, 16'h0008);
        check_eq("single_wd", WriteData, 16'hBEEF);
        check_eq("single_cnt", count, 3'd1);
        tick();
        check_eq("single_done", WriteReg, 16'h0000);
        check_eq("single_empty", empty, 1'b1);

        // fill with drain stalled; head sits at slot 1 so the fill wraps
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_addr = 4'(i); wb_data = 16'(i);
            tick();
        end
        wb_valid = 1'b0;
        #1;
        check_eq("fill_full", full, 1'b1);
        check_eq("fill_count", count, 3'd4);
        check_eq("fill_ready", wb_ready, 1'b0);
        check_eq("fill_nowr", WriteReg, 16'h0000);
        drain_en = 1'b1; wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h0005;
        #1;
        check_eq("full_drain_ready", wb_ready, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            check_eq("drain_wr", WriteReg, 32'(16'h0001 << k));
            check_eq("drain_wd", WriteData, 32'(k));
            if (k == 1) begin
                tick();
                wb_valid = 1'b0;
                #1;
                check_eq("pushpop_count", count, 3'd4);
            end else begin
                tick();
            end
        end
        check_eq("drain_empty", empty, 1'b1);
        check_eq("drain_idle", WriteReg, 16'h0000);

        // forwarding priority: youngest match wins, incoming request not forwarded
        drain_en = 1'b0; rd_addr1 = 4'd7; rf_rdata1 = 16'h0000;
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'hAAAA;
        tick();
        wb_data = 16'hBBBB;
        #1;
        check_eq("fwd_no_incoming", rd_data1, 16'hAAAA);
        tick();
        wb_valid = 1'b0;
        check_eq("fwd_youngest", rd_data1, 16'hBBBB);
        drain_en = 1'b1;
        #1;
        check_eq("fwd_drain1_wr", WriteReg, 16'h0080);
        check_eq("fwd_drain1_wd", WriteData, 16'hAAAA);
        tick();
        check_eq("fwd_head_only", rd_data1, 16'hBBBB);
        tick();
        rf_rdata1 = 16'h1357;
        #1;
        check_eq("fwd_after_drain", rd_data1, 16'h1357);

        // R0 write accepted but dropped; R0 reads as zero
        drain_en = 1'b0; wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
        #1;
        check_eq("r0_ready", wb_ready, 1'b1);
        tick();
        wb_valid = 1'b0; drain_en = 1'b1;
        rd_addr2 = 4'd0; rf_rdata2 = 16'h5555;
        #1;
        check_eq("r0_count", count, 3'd0);
        check_eq("r0_nowr", WriteReg, 16'h0000);
        check_eq("r0_rd2", rd_data2, 16'h0000);
        check_eq("r0_re2", ReadEnable2, 16'h0001);

        // reset mid-operation discards pending writes
        drain_en = 1'b0;
        wb_valid = 1'b1; wb_addr = 4'd9;  wb_data = 16'h1111; tick();
        wb_valid = 1'b1; wb_addr = 4'd10; wb_data = 16'h2222; tick();
        wb_valid = 1'b1; wb_addr = 4'd9;  wb_data = 16'h3333; tick();
        wb_valid = 1'b0;
        rd_addr1 = 4'd9; rf_rdata1 = 16'h0000; rd_addr2 = 4'd10; rf_rdata2 = 16'h0000;
        #1;
        check_eq("pre_rst_count", count, 3'd3);
        check_eq("pre_rst_rd1", rd_data1, 16'h3333);
        check_eq("pre_rst_rd2", rd_data2, 16'h2222);
        rst = 1'b0;
        tick();
        rst = 1'b1; drain_en = 1'b1; rf_rdata1 = 16'h4444; rf_rdata2 = 16'h6666;
        #1;
        check_eq("mid_rst_count", count, 3'd0);
        check_eq("mid_rst_empty", empty, 1'b1);
        check_eq("mid_rst_wr", WriteReg, 16'h0000);
        check_eq("mid_rst_rd1", rd_data1, 16'h4444);
        check_eq("mid_rst_rd2", rd_data2, 16'h6666);
        tick();
        check_eq("mid_rst_wr2", WriteReg, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
Write-back staging block that sits directly upstream of the 16-entry register file. It accepts write-back requests through a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file as a one-hot WriteReg vector plus write data. It also decodes the two read addresses into one-hot ReadEnable vectors and forwards pending, not-yet-committed write data to the read outputs.

Parameters:
DATA_W, 16, register/bitline width
NUM_REGS, 16, registers in file; width of one-hot enable vectors
ADDR_W, 4, register address width (log2 NUM_REGS)
DEPTH, 4, write-back FIFO entries (power of two, >=2)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
wb_valid  input  1  write-back request present
wb_ready  output  1  request accepted when wb_valid & wb_ready at clock edge
wb_addr  input  ADDR_W  destination register
wb_data  input  DATA_W  value to write
drain_en  input  1  register file may accept a write this cycle
WriteReg  output  NUM_REGS  one-hot write enable to register file (all-zero = no write)
WriteData  output  DATA_W  data driven to register file with WriteReg
rd_addr1, rd_addr2  input  ADDR_W  read port source registers
ReadEnable1, ReadEnable2  output  NUM_REGS  one-hot read enables, combinational decode of rd_addrN
rf_rdata1, rf_rdata2  input  DATA_W  data returned on register file bitlines
rd_data1, rd_data2  output  DATA_W  forwarded read result
count  output  $clog2(DEPTH)+1  entries held
full, empty  output  1  count==DEPTH / count==0

Behaviour:
- Reset (rst==0 at edge): head/tail pointers and count cleared, all entries invalidated; next cycle WriteReg=0, count=0, empty=1, full=0, wb_ready=1. Reset mid-drain discards all pending writes and the register file sees no further write from them.
- FIFO: circular, head/tail wrap modulo DEPTH. Push on wb_valid&wb_ready. Pop at edge when !empty & drain_en.
- Write to R0 (wb_addr==0): handshake completes, entry not stored, count unchanged (R0 hardwired zero).
- wb_ready = !full | drain_en. When full and draining, push and pop happen on the same edge; count stays DEPTH.
- Drain output is combinational from the head: WriteReg = (!empty & drain_en) ? onehot(head.addr) : 0; WriteData = head.data. WriteData is don't-care when WriteReg==0.
- Latency: a request accepted at edge N into an empty FIFO drives WriteReg during cycle N+1 and commits at edge N+1 (if drain_en). No same-cycle pass-through from wb_* to WriteReg.
- Simultaneous push/pop at count==k: count stays k, pointers both advance.
- ReadEnableN = onehot(rd_addrN) always, including R0.
- Forwarding per read port:
  - rd_addrN==0: output 0.
  - Otherwise, if any valid entry matches rd_addrN, output the youngest matching entry's data (tail-most). The head is included.
  - Otherwise, output rf_rdataN.
  - The incoming wb_* request of the same cycle is not forwarded.
- Ordering: entries commit strictly in acceptance order. Duplicate addresses are allowed; the last accepted value wins in both forwarding and final register contents.
- Arithmetic: count is full-width, never exceeds DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset then idle: rst=0 one edge -> WriteReg=0, count=0, empty=1, wb_ready=1; rd_addr1=5, rf_rdata1=16'h1234 -> rd_data1=16'h1234, ReadEnable1=16'h0020.
- Single write, drain_en=1: push R3=16'hBEEF at edge N -> cycle N+1 WriteReg=16'h0008, WriteData=16'hBEEF; cycle N+2 WriteReg=0, empty=1.
- Fill/stall: drain_en=0, push R1..R4 with data 16'h0001..16'h0004 -> full=1, count=4, wb_ready=0; raise drain_en and push R5=16'h0005 -> count stays 4; WriteReg sequence 0x0002,0x0004,0x0008,0x0010,0x0020 with matching data; pointer wrap verified.
- Forwarding priority: drain_en=0, push R7=16'hAAAA then R7=16'hBBBB; rd_addr1=7, rf_rdata1=16'h0000 -> rd_data1=16'hBBBB; after both drain -> rd_data1 follows rf_rdata1.
- R0 handling: push R0=16'hFFFF -> accepted, count unchanged, no WriteReg; rd_addr2=0 with rf_rdata2=16'h5555 -> rd_data2=0, ReadEnable2=16'h0001.
- Reset mid-operation: three entries pending, drain_en=0, rst=0 one edge -> count=0, WriteReg=0 thereafter even with drain_en=1; forwarding returns rf_rdata.
